game_flow_controller: RTL
=========================

// Module: game_flow_controller
// PURPOSE
//  Top-level game sequencer for Lane Surfer: owns the IDLE/PLAY/HIT/GAME_OVER flow and the lives count.
//  Merges N_SRC per-obstacle collision flags into life-loss events. Holds post-hit invulnerability, timed
//  in VGA frames, and gates obstacle motion. Sits between the collision detectors, the obstacle movers,
//  the player renderer and the HEX lives display.
// PARAMETERS
//  N_SRC          4    number of collision sources (one per obstacle)
//  LIVES_W        2    width of lives counter
//  START_LIVES    3    lives loaded on game start and on reset (must be >=1, fit in LIVES_W)
//  INVULN_FRAMES  120  frames of invulnerability after a non-fatal hit (1..255)
//  BLINK_FRAMES   8    frames per player_visible toggle while invulnerable (INVULN_BLINK_EN only)
// PORTS
//  Clock          in   1        system clock
//  Resetn         in   1        synchronous, active-low reset
//  start          in   1        start/restart request, active-high level, already synchronized
//  frame_tick     in   1        1-cycle pulse once per VGA frame
//  collision_vec  in   N_SRC    per-obstacle collision levels
//  state          out  2        current FSM state (encoding in game_defs.vh)
//  lives          out  LIVES_W  remaining lives
//  game_active    out  1        1 in PLAY or HIT
//  obstacles_run  out  1        obstacle movers may advance (PLAY or HIT)
//  invulnerable   out  1        1 in HIT
//  life_lost      out  1        1-cycle pulse per accepted collision
//  game_over      out  1        1 in GAME_OVER
//  clear_req      out  1        1-cycle pulse on GAME_OVER->IDLE (screen/obstacle clear)
//  player_visible out  1        player sprite enable
// BEHAVIOUR
//  Reset: state=IDLE, lives=START_LIVES, invuln counter=0, all edge-detect history=0, pulses=0,
//   game_over=0, player_visible=1. Reset wins over every other event in the same cycle.
//  Edges: start_rise = start & ~start_q. hit_rise = |collision_vec & ~coll_q, with coll_q=|collision_vec
//   registered every cycle in all states. A collision still held across state changes never re-triggers.
//  IDLE: on start_rise -> PLAY, lives<=START_LIVES. Collisions are ignored.
//  PLAY: on hit_rise, life_lost=1 in the next cycle.
//   If lives==1: lives<=0 and -> GAME_OVER.
//   Else: lives<=lives-1, counter<=INVULN_FRAMES, -> HIT.
//   start is ignored. Simultaneous hits from several sources in one cycle cost exactly one life.
//  HIT: collisions are ignored. On frame_tick the counter decrements. When the counter is 1 and frame_tick
//   arrives, counter<=0 and -> PLAY next cycle. A collision in that same cycle is not counted; only a later
//   rise counts.
//  GAME_OVER: lives stays 0 and obstacles_run=0. On start_rise -> IDLE with clear_req=1 for one cycle.
//   A start still held high after the restart needs release and press again to leave IDLE.
//  Outputs are registered or decoded purely from state. life_lost and clear_req are registered and high
//   for exactly 1 cycle. lives never underflows and never exceeds START_LIVES.
//  Latency: collision rise to lives/state update is 1 cycle; start rise to state change is 1 cycle.
// CONFIGURATION
//  INVULN_BLINK_EN defined: in HIT, a frame counter toggles player_visible every BLINK_FRAMES frame_ticks,
//   starting at 0 on entry to HIT. player_visible is forced to 1 on exit from HIT and in all other states.
//  INVULN_BLINK_EN undefined: player_visible is constant 1 and no blink logic is synthesized.
// STRUCTURE
//  game_defs.vh: state encodings S_IDLE=2'd0, S_PLAY=2'd1, S_HIT=2'd2, S_OVER=2'd3. Shared with the
//   renderer and obstacle movers.
//  Sub-module rise_detect (1-bit registered rising-edge detector, synchronous active-low reset),
//   instantiated for start and for |collision_vec.
//  HEX lives display is driven externally from the lives output.
// TESTING
//  1. Reset, start pulse -> state PLAY after 1 cycle, lives=3, obstacles_run=1.
//  2. PLAY, collision_vec=4'b0110 for 1 cycle -> one life_lost pulse, lives=2, state HIT, invulnerable=1.
//  3. HIT, collisions every 10 frames, INVULN_FRAMES=120 -> lives stays 2. On the 120th frame_tick
//     -> state PLAY.
//  4. Collision held high from HIT into PLAY -> no loss; drop and re-raise it -> lives=1.
//  5. lives=1, collision -> lives=0, game_over=1, obstacles_run=0. Start -> IDLE with 1-cycle clear_req.
//  6. With INVULN_BLINK_EN, BLINK_FRAMES=8 -> player_visible toggles every 8 frame_ticks in HIT and is 1
//     after exit. Without the macro -> player_visible is always 1.

Source files
------------

// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the Lane Surfer game flow controller.
// The state encoding is shared with the renderer and the obstacle movers.
package game_flow_controller_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_HIT  = 2'd2,
      S_OVER = 2'd3
   } game_state_e;

   // Width of the invulnerability frame counter (INVULN_FRAMES is 1..255)
   localparam int INV_W = 8;

endpackage

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game flow controller and its surroundings.
// master: collision detectors / frame timing side; slave: the controller.
interface game_flow_controller_if #(
   parameter int N_SRC   = 4,
   parameter int LIVES_W = 2
);
   logic               start;
   logic               frame_tick;
   logic [N_SRC-1:0]   collision_vec;
   logic [1:0]         state;
   logic [LIVES_W-1:0] lives;
   logic               game_active;
   logic               obstacles_run;
   logic               invulnerable;
   logic               life_lost;
   logic               game_over;
   logic               clear_req;
   logic               player_visible;

   modport master (
      output start, frame_tick, collision_vec,
      input  state, lives, game_active, obstacles_run, invulnerable,
             life_lost, game_over, clear_req, player_visible
   );

   modport slave (
      input  start, frame_tick, collision_vec,
      output state, lives, game_active, obstacles_run, invulnerable,
             life_lost, game_over, clear_req, player_visible
   );
endinterface

// File: rtl/game_flow_controller_rise_detect.sv
// One-bit rising-edge detector: history is registered every cycle, the
// rise output is the current level against that history.
module game_flow_controller_rise_detect (
   input  logic Clock,
   input  logic Resetn,
   input  logic d_i,
   output logic rise_o
);
   logic d_q;

   // Remember last cycle's level; cleared by reset
   always_ff @(posedge Clock) begin
      if (!Resetn) d_q <= 1'b0;
      else         d_q <= d_i;
   end

   assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/game_flow_controller.sv
// Lane Surfer game sequencer: IDLE/PLAY/HIT/GAME_OVER flow, lives count,
// post-hit invulnerability timed in frames and obstacle motion gating.
// Optional blinking of the player while invulnerable: INVULN_BLINK_EN.
module game_flow_controller
   import game_flow_controller_pkg::*;
#(
   parameter int N_SRC         = 4,
   parameter int LIVES_W       = 2,
   parameter int START_LIVES   = 3,
`ifdef INVULN_BLINK_EN
   parameter int BLINK_FRAMES  = 8,
`endif
   parameter int INVULN_FRAMES = 120
) (
   input  logic                   Clock,
   input  logic                   Resetn,
   game_flow_controller_if.slave  bus
);
   localparam logic [LIVES_W-1:0] START_L = LIVES_W'(START_LIVES);
   localparam logic [LIVES_W-1:0] ONE_L   = LIVES_W'(1);
   localparam logic [INV_W-1:0]   INV_L   = INV_W'(INVULN_FRAMES);

   logic coll_any, start_rise, hit_rise;

   game_state_e        state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [INV_W-1:0]   inv_q, inv_d;
   logic               life_lost_q, life_lost_d;
   logic               clear_req_q, clear_req_d;

   assign coll_any = |bus.collision_vec[N_SRC-1:0];

   game_flow_controller_rise_detect u_start_rise (
      .Clock (Clock), .Resetn (Resetn), .d_i (bus.start), .rise_o (start_rise)
   );

   game_flow_controller_rise_detect u_hit_rise (
      .Clock (Clock), .Resetn (Resetn), .d_i (coll_any), .rise_o (hit_rise)
   );

   // State, lives, invulnerability timer and one-cycle pulse registers
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q     <= S_IDLE;
         lives_q     <= START_L;
         inv_q       <= '0;
         life_lost_q <= 1'b0;
         clear_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         inv_q       <= inv_d;
         life_lost_q <= life_lost_d;
         clear_req_q <= clear_req_d;
      end
   end

   // Game flow: collisions only count in PLAY, and only on a fresh rise
   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      inv_d       = inv_q;
      life_lost_d = 1'b0;
      clear_req_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d = S_PLAY;
               lives_d = START_L;
            end
         end
         S_PLAY: begin
            if (hit_rise) begin
               life_lost_d = 1'b1;
               if (lives_q == ONE_L) begin
                  lives_d = '0;
                  state_d = S_OVER;
               end else begin
                  lives_d = lives_q - ONE_L;
                  inv_d   = INV_L;
                  state_d = S_HIT;
               end
            end
         end
         S_HIT: begin
            if (bus.frame_tick) begin
               if (inv_q == INV_W'(1)) begin
                  inv_d   = '0;
                  state_d = S_PLAY;
               end else begin
                  inv_d = inv_q - INV_W'(1);
               end
            end
         end
         S_OVER: begin
            lives_d = '0;
            if (start_rise) begin
               state_d     = S_IDLE;
               clear_req_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.state         = state_q;
   assign bus.lives         = lives_q;
   assign bus.game_active   = (state_q == S_PLAY) || (state_q == S_HIT);
   assign bus.obstacles_run = (state_q == S_PLAY) || (state_q == S_HIT);
   assign bus.invulnerable  = (state_q == S_HIT);
   assign bus.game_over     = (state_q == S_OVER);
   assign bus.life_lost     = life_lost_q;
   assign bus.clear_req     = clear_req_q;

`ifdef INVULN_BLINK_EN
   localparam logic [INV_W-1:0] BLINK_LAST = INV_W'(BLINK_FRAMES - 1);

   logic [INV_W-1:0] blink_q, blink_d;
   logic             vis_q, vis_d;

   // Blink phase register; visible and phase cleared by reset
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         blink_q <= '0;
         vis_q   <= 1'b1;
      end else begin
         blink_q <= blink_d;
         vis_q   <= vis_d;
      end
   end

   // Toggle every BLINK_FRAMES ticks while staying in HIT; visible elsewhere
   always_comb begin
      blink_d = blink_q;
      vis_d   = vis_q;
      if (state_d != S_HIT) begin
         blink_d = '0;
         vis_d   = 1'b1;
      end else if ((state_q == S_HIT) && bus.frame_tick) begin
         if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            vis_d   = ~vis_q;
         end else begin
            blink_d = blink_q + INV_W'(1);
         end
      end
   end

   assign bus.player_visible = vis_q;
`else
   assign bus.player_visible = 1'b1;
`endif

endmodule
